// File: rtl/jk_stim_seq.sv
// Command-driven J/K stimulus sequencer: queues {j,k}+hold commands in a small
// FIFO and plays each pair for hold+1 cycles, returning to the JK hold code when idle.
module jk_stim_seq #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_jk,
    input  logic [HOLD_W-1:0]        cmd_hold,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, PLAY} state_t;

    logic [HOLD_W+1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    state_t            state_q, state_d;
    logic [1:0]        jk_q, jk_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;

    logic              push, pop, fifo_empty;
    logic [1:0]        head_jk;
    logic [HOLD_W-1:0] head_hold;

    // Ready is taken from the registered count only, so a full FIFO never
    // accepts a push even on the cycle it pops.
    assign cmd_ready  = (count_q != CNT_W'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count_q == '0);
    assign head_jk    = mem_q[rd_ptr_q][HOLD_W+1:HOLD_W];
    assign head_hold  = mem_q[rd_ptr_q][HOLD_W-1:0];

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= {cmd_jk, cmd_hold};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            jk_q    <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            jk_q    <= jk_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        jk_d    = jk_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                jk_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    jk_d    = head_jk;
                    hold_d  = head_hold;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (!fifo_empty) begin
                    pop    = 1'b1;
                    jk_d   = head_jk;
                    hold_d = head_hold;
                end else begin
                    state_d = IDLE;
                    jk_d    = '0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    assign j          = jk_q[1];
    assign k          = jk_q[0];
    assign busy       = (state_q == PLAY);
    assign done       = done_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_jk_stim_seq.sv
// Bench for jk_stim_seq: directed scenarios then random traffic, every cycle
// compared against a queue-based playback model.
module tb_jk_stim_seq;

    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_jk;
    logic [HOLD_W-1:0] cmd_hold;
    logic              j, k, busy, done;
    logic [CW-1:0]     fifo_count;

    jk_stim_seq #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_jk     (cmd_jk),
        .cmd_hold   (cmd_hold),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  jk;
        int unsigned hold;
    } cmd_t;

    cmd_t        mq[$];
    logic [1:0]  m_cur;
    int unsigned m_rem;     // cycles left on the pair being driven, 0 = idle
    bit          m_done;
    bit          m_acc;

    int checks = 0;
    int fails  = 0;
    int done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic v, input logic [1:0] jk,
                              input logic [HOLD_W-1:0] h);
        cmd_t c;
        if (!rst) begin
            mq.delete();
            m_rem  = 0;
            m_cur  = 2'b00;
            m_done = 1'b0;
            m_acc  = 1'b0;
        end else begin
            m_acc  = v && (mq.size() < DEPTH);
            m_done = 1'b0;
            if (m_rem > 1) begin
                m_rem--;
            end else if (mq.size() > 0) begin
                c     = mq.pop_front();
                m_cur = c.jk;
                m_rem = c.hold + 1;
            end else if (m_rem == 1) begin
                m_rem  = 0;
                m_done = 1'b1;
            end
            if (m_acc) begin
                c.jk   = jk;
                c.hold = h;
                mq.push_back(c);
            end
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [1:0] jk,
                        input logic [HOLD_W-1:0] h);
        logic [1:0] exp_jk;
        reset     = rst;
        cmd_valid = v;
        cmd_jk    = jk;
        cmd_hold  = h;
        @(posedge clk);
        model_edge(rst, v, jk, h);
        #1;
        exp_jk = (m_rem > 0) ? m_cur : 2'b00;
        chk("j",          32'(j),          32'(exp_jk[1]));
        chk("k",          32'(k),          32'(exp_jk[0]));
        chk("busy",       32'(busy),       32'(m_rem > 0));
        chk("done",       32'(done),       32'(m_done));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("cmd_ready",  32'(cmd_ready),  32'(mq.size() != DEPTH));
        if (done === 1'b1) done_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, '0);
    endtask

    initial begin
        int d0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_jk = '0; cmd_hold = '0;

        // reset held with valid high: nothing may be queued
        step(1'b0, 1'b1, 2'b11, 4'hF);
        step(1'b0, 1'b1, 2'b11, 4'hF);
        idle(2);

        // single command 10 / hold 2
        step(1'b1, 1'b1, 2'b10, 4'd2);
        idle(6);

        // back-to-back, exactly one done pulse
        d0 = done_seen;
        step(1'b1, 1'b1, 2'b11, 4'd0);
        step(1'b1, 1'b1, 2'b01, 4'd0);
        step(1'b1, 1'b1, 2'b10, 4'd1);
        idle(8);
        chk("b2b_done_pulses", 32'(done_seen - d0), 32'd1);

        // fill the FIFO with long holds; keep valid high until each is taken
        for (int i = 0; i < 7; i++) begin
            int t = 0;
            m_acc = 1'b0;
            while (!m_acc && t < 100) begin
                step(1'b1, 1'b1, 2'(i), 4'd15);
                t++;
            end
            chk("full_accept_in_time", 32'(m_acc), 32'd1);
        end
        for (int t = 0; t < 200 && (m_rem > 0 || mq.size() > 0); t++) idle(1);
        idle(2);
        chk("full_drained", 32'(busy), 32'd0);

        // reset during 3rd cycle of a hold=7 command with 2 queued
        d0 = done_seen;
        step(1'b1, 1'b1, 2'b11, 4'd7);
        step(1'b1, 1'b1, 2'b01, 4'd1);
        step(1'b1, 1'b1, 2'b10, 4'd1);
        idle(1);
        step(1'b0, 1'b0, 2'b00, '0);
        idle(6);
        chk("abort_no_done", 32'(done_seen - d0), 32'd0);

        // push while the FSM pops at count 2
        step(1'b1, 1'b1, 2'b10, 4'd3);
        step(1'b1, 1'b1, 2'b01, 4'd0);
        step(1'b1, 1'b1, 2'b11, 4'd0);
        idle(2);
        step(1'b1, 1'b1, 2'b10, 4'd2);
        chk("simul_count", 32'(fifo_count), 32'd2);
        idle(10);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            logic rst_r;
            logic [HOLD_W-1:0] h;
            rst_r = ($urandom_range(0, 59) != 0);
            h = ($urandom_range(0, 7) == 0) ? HOLD_W'($urandom) : HOLD_W'($urandom_range(0, 3));
            step(rst_r, 1'($urandom_range(0, 2) != 0), 2'($urandom), h);
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/jk_stim_seq.md
# jk_stim_seq

Command-driven stimulus sequencer that sits directly upstream of the `jk_ff` stage and produces its `j`/`k` inputs. Software or a bench pushes `{j,k}` commands, each with a hold count, through a valid/ready interface into a small FIFO. A playback FSM then drives each pair onto `j`/`k` for a programmed number of cycles. When idle it returns to the JK "hold" code (`j=k=0`).

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO depth; must be a power of 2 and at least 2.
- `HOLD_W`, default 4: width of the per-command hold field.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset), sampled on rising `clk`.
- `cmd_valid`  input  1  command present on `cmd_jk` and `cmd_hold`.
- `cmd_ready`  output  1  FIFO can accept a command.
- `cmd_jk`  input  2  `{j,k}` pair to drive.
- `cmd_hold`  input  HOLD_W  the pair is driven for `cmd_hold+1` cycles.
- `j`  output  1  registered J drive to the `jk_ff` stage.
- `k`  output  1  registered K drive to the `jk_ff` stage.
- `busy`  output  1  high while the FSM is in PLAY.
- `done`  output  1  one-cycle pulse when the last queued command finishes.
- `fifo_count`  output  $clog2(DEPTH)+1  number of commands queued (excludes the one playing).

## Operation
- Push: the FIFO writes on any edge where `cmd_valid && cmd_ready`.
- `cmd_ready = (fifo_count != DEPTH)`, combinational from the registered count.
  - No push-through when full: ready stays low even if a pop happens in the same cycle.
- FIFO:
  - Circular buffer with `$clog2(DEPTH)`-bit read and write pointers that wrap modulo DEPTH.
  - Count is updated by +1 on push only, −1 on pop only, and is unchanged on a simultaneous push and pop.
- FSM states: IDLE, PLAY.
  - **IDLE:** `j=k=0`, `busy=0`.
    - If the FIFO is non-empty: pop, load `{j,k}` and `hold_cnt=cmd_hold`, go to PLAY.
  - **PLAY:** `busy=1`.
    - If `hold_cnt!=0`: decrement.
    - Else if the FIFO is non-empty: pop the next command, load it, stay in PLAY. There is no gap cycle between commands.
    - Else: go to IDLE, set `j=k=0`, assert `done` for exactly one cycle.
- A push into an empty FIFO and a pop from it cannot happen in the same cycle. A pushed entry becomes visible to the FSM on the following edge.
- `cmd_jk`/`cmd_hold` are ignored when `cmd_valid=0`.
- Reset (`reset=0` at an edge), including mid-PLAY:
  - Pointers and count go to 0 and queued commands are discarded.
  - State returns to IDLE.
  - `j=0`, `k=0`, `busy=0`, `done=0`.
  - `cmd_ready=1` after the reset edge.
  - No `done` pulse is generated for aborted commands.
  - Pushes are ignored while `reset=0`.

## Timing
- Reset values: `j=0`, `k=0`, `busy=0`, `done=0`, `fifo_count=0`, `cmd_ready=1`.
- Latency when IDLE:
  - Command accepted at edge N; popped at edge N+1.
  - `j`/`k` are valid from edge N+1 for exactly `cmd_hold+1` cycles.
- Back-to-back commands: the next pair appears on the edge immediately after the previous pair's final cycle.
- `done` rises on the same edge that `j`/`k` return to 0 and `busy` falls. It is high for exactly one cycle.
- `hold_cnt` is HOLD_W bits. The maximum hold is `2^HOLD_W` cycles (15 → 16 cycles for the default). There is no overflow path.
- All outputs except `cmd_ready` are registered.

## Test plan
- **Reset:** hold `reset=0` for 2 edges while `cmd_valid=1`.
  - Expect `j=k=0`, `busy=0`, `done=0`, `fifo_count=0`, `cmd_ready=1`, and nothing queued after release.
- **Single command:** push `cmd_jk=2'b10`, `cmd_hold=2` at edge 1.
  - Expect `j=1,k=0` at edges 2–4 (3 cycles).
  - At edge 5, `j=k=0`, `busy=0`, `done=1`; at edge 6, `done=0`.
- **Back-to-back:** push `11/h0`, `01/h0`, `10/h1` on consecutive edges.
  - Expect `{j,k}` = 11, 01, 10, 10 on consecutive cycles with no idle gap, then exactly one `done` pulse.
- **Full FIFO:** push 7 commands with `cmd_hold=15`.
  - The first starts playing; after 4 more are queued, `fifo_count=4` and `cmd_ready=0`.
  - The 6th is accepted only on the edge after the next pop. Entries play in push order, confirming pointer wrap.
- **Reset mid-PLAY:** assert `reset=0` during the 3rd cycle of a `hold=7` command with 2 queued.
  - Next edge: `j=k=0`, `fifo_count=0`, `busy=0`, and `done` never pulses.
- **Simultaneous push/pop:** at count=2, push on the same edge the FSM pops.
  - `fifo_count` stays 2 and the new entry plays last.
